vm1_dma_arb: RTL



---
 rtl/vm1_pkg.sv | 42 ++++
 rtl/vm1_sync2.sv | 25 ++
 rtl/vm1_dma_arb.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/vm1_pkg.sv
// Shared types and helpers for the VM1 Qbus DMA mastership controller.
package vm1_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    OWN  = 3'd3,
    REL  = 3'd4
  } arb_state_e;

  localparam int NREQ_DEF    = 4;
  localparam int GNT_TMO_DEF = 255;

  // Requester indices are carried at a fixed width wide enough for the
  // largest supported requester count.
  localparam int NREQ_MAX = 8;
  localparam int IDX_W    = 3;

  // Round-robin pick: first set bit of req searching upward from ptr+1,
  // wrapping at n. Returns ptr unchanged when nothing is requesting.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ_MAX-1:0] req,
                                               input logic [IDX_W-1:0]    ptr,
                                               input int                  n);
    logic [IDX_W-1:0] res;
    logic             found;
    int               idx;
    res   = ptr;
    found = 1'b0;
    for (int i = 1; i <= NREQ_MAX; i++) begin
      if (i <= n && !found) begin
        idx = (int'(ptr) + i) % n;
        if (req[idx[IDX_W-1:0]]) begin
          res   = idx[IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vm1_sync2.sv
// Two-flop synchroniser for an asynchronous bus line; resets to 0.
module vm1_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Capture the raw line, then let any metastability settle in the second flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/vm1_dma_arb.sv
// Qbus DMA bus-mastership controller: round-robin arbitration of local
// requesters and the DMR/DMGI/DMGO/SACK handshake to take the bus.
//
//   state | meaning
//   IDLE  | no local owner; grant-in is passed downstream on bus_dmgo
//   REQ   | DMR asserted for the latched winner, waiting for grant-in
//   WAIT  | grant taken, SACK asserted, previous master still finishing
//   OWN   | winner owns the bus, dev_gnt asserted
//   REL   | SACK dropped, waiting for grant-in to fall before re-arming
module vm1_dma_arb
  import vm1_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TMO_W   = 8,
  parameter int GNT_TMO = GNT_TMO_DEF
) (
  input  logic            pin_clk,
  input  logic            pin_dclo_n,
  input  logic [NREQ-1:0] dev_req,
  output logic [NREQ-1:0] dev_gnt,
  output logic            bus_dmr_out,
  input  logic            bus_dmgi,
  output logic            bus_dmgo,
  input  logic            bus_sack_in,
  output logic            bus_sack_out,
  input  logic            bus_sync_in,
  input  logic            bus_rply_in,
  output logic            arb_tmo
);

  // Last cycle of REQ before giving up: REQ lasts exactly GNT_TMO cycles.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GNT_TMO - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             dmgo_q, dmgo_d;

  logic dmgi_s, sack_s, sync_s, rply_s;
  logic [NREQ_MAX-1:0] req_ext;
  logic win_req;
  logic tmo_hit;

  vm1_sync2 u_sync_dmgi (.clk_i(pin_clk), .rst_ni(pin_dclo_n), .d_i(bus_dmgi),    .q_o(dmgi_s));
  vm1_sync2 u_sync_sack (.clk_i(pin_clk), .rst_ni(pin_dclo_n), .d_i(bus_sack_in), .q_o(sack_s));
  vm1_sync2 u_sync_sync (.clk_i(pin_clk), .rst_ni(pin_dclo_n), .d_i(bus_sync_in), .q_o(sync_s));
  vm1_sync2 u_sync_rply (.clk_i(pin_clk), .rst_ni(pin_dclo_n), .d_i(bus_rply_in), .q_o(rply_s));

  // Widen the request vector so the latched winner index can address it directly.
  always_comb begin
    req_ext = '0;
    req_ext[NREQ-1:0] = dev_req;
  end

  assign win_req = req_ext[winner_q];
  // A grant arriving in the same cycle as the timeout still wins.
  assign tmo_hit = (state_q == REQ) && !dmgi_s && win_req && (cnt_q == TMO_LAST);

  // State register.
  always_ff @(posedge pin_clk or negedge pin_dclo_n) begin
    if (!pin_dclo_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!dmgi_s && (|dev_req)) state_d = REQ;
      REQ: begin
        if (dmgi_s)       state_d = WAIT;
        else if (!win_req) state_d = IDLE;
        else if (tmo_hit)  state_d = IDLE;
      end
      // A requester that withdraws while the old master is still active is
      // released rather than handed a bus it no longer wants.
      WAIT: begin
        if (!win_req)               state_d = REL;
        else if (!sync_s && !rply_s) state_d = OWN;
      end
      OWN:  if (!win_req) state_d = REL;
      REL:  if (!dmgi_s)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus and grant outputs decoded from the registered state only.
  always_comb begin
    bus_dmr_out  = (state_q == REQ) || (state_q == WAIT);
    bus_sack_out = (state_q == WAIT) || (state_q == OWN);
    dev_gnt      = '0;
    for (int i = 0; i < NREQ; i++) begin
      dev_gnt[i] = (state_q == OWN) && (winner_q == IDX_W'(i));
    end
  end

  assign bus_dmgo = dmgo_q;
  assign arb_tmo  = tmo_q;

  // Winner latch, round-robin pointer, timeout counter and registered pulses.
  always_comb begin
    winner_d = winner_q;
    if (state_q == IDLE && state_d == REQ) begin
      winner_d = rr_pick(req_ext, ptr_q, NREQ);
    end
    ptr_d  = (state_q == REL) ? winner_q : ptr_q;
    cnt_d  = (state_q == REQ) ? cnt_q + 1'b1 : '0;
    tmo_d  = tmo_hit;
    dmgo_d = (state_q == IDLE) ? dmgi_s : 1'b0;
  end

  // Datapath registers; pointer resets so requester 0 is served first.
  always_ff @(posedge pin_clk or negedge pin_dclo_n) begin
    if (!pin_dclo_n) begin
      winner_q <= '0;
      ptr_q    <= IDX_W'(NREQ - 1);
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
      dmgo_q   <= 1'b0;
    end else begin
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      dmgo_q   <= dmgo_d;
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge pin_clk) disable iff (!pin_dclo_n)
    $onehot0(dev_gnt));
  a_gnt_sack: assert property (@(posedge pin_clk) disable iff (!pin_dclo_n)
    (|dev_gnt) |-> bus_sack_out);
  a_dmgo_dmr: assert property (@(posedge pin_clk) disable iff (!pin_dclo_n)
    !(bus_dmgo && bus_dmr_out));
  // Another master holding SACK while we are idle or requesting.
  c_foreign_sack: cover property (@(posedge pin_clk) disable iff (!pin_dclo_n)
    sack_s && (state_q == IDLE || state_q == REQ));
`endif

endmodule
